// File: rtl/uart_rx_fifo_if.sv
// Read port of the UART receive FIFO: head data, head error tag and a
// valid/ready pop handshake. The receiver drives the master side.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rdata_o;
  logic [1:0]           rerr_o;   // bit0 framing, bit1 parity
  logic                 rvalid_o;
  logic                 rready_i;

  modport master (output rdata_o, output rerr_o, output rvalid_o, input rready_i);
  modport slave  (input rdata_o, input rerr_o, input rvalid_o, output rready_i);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable framing, per-character error
// tags and a first-word-fall-through receive FIFO.
// Optional feature: define UART_RX_BREAK_DETECT_EN to add break_o, which
// pulses once when the line is held low for a full frame; the break is then
// swallowed instead of being pushed as a 0x00 framing-error character.
module uart_rx_fifo #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rx_i,
  input  logic                        rx_en_i,
  input  logic                        clear_i,
  uart_rx_fifo_if.master              rd,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overrun_o,
  output logic                        busy_o
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                        break_o
`endif
);

  localparam int TICK_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int DIV_RAW   = (CLOCK_RATE + TICK_RATE / 2) / TICK_RATE;
  localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW        = $clog2(OVERSAMPLE);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LW        = AW + 1;
  localparam int EW        = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [OW-1:0]        os_q, os_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic [1:0]           sync_q, sync_d;
  logic                 prev_q, prev_d;
  logic [LW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic                 ovr_q, ovr_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 brk_q, brk_d, brkhit_q, brkhit_d, break_q, break_d;
`endif

  logic          rxs, tick, samp_half, samp_full, exp_par, ferr_n;
  logic          push, wr_en, pop, full, empty;
  logic [1:0]    push_err;
  logic [LW-1:0] level;
  logic [EW-1:0] head;

  assign rxs       = sync_q[1];
  assign tick      = (state_q != S_IDLE) && (div_q == DW'(DIV - 1));
  assign samp_half = tick && (os_q == OW'(OVERSAMPLE / 2 - 1));
  assign samp_full = tick && (os_q == OW'(OVERSAMPLE - 1));
  assign exp_par   = (PARITY == 1) ? ~(^data_q) : (^data_q);
  assign ferr_n    = ferr_q | ~rxs;

  // Receive FSM, tick divider and sample counters: next-state logic.
  always_comb begin
    state_d  = state_q;
    div_d    = (state_q == S_IDLE || tick) ? '0 : div_q + DW'(1);
    os_d     = tick ? os_q + OW'(1) : os_q;
    bit_d    = bit_q;
    data_d   = data_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    sync_d   = {sync_q[0], rx_i};
    prev_d   = rxs;
    push     = 1'b0;
    push_err = {perr_q, ferr_n};
`ifdef UART_RX_BREAK_DETECT_EN
    brk_d    = brk_q;
    brkhit_d = brkhit_q;
    break_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_en_i && prev_q && !rxs) begin
          state_d = S_START;
          os_d    = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (samp_half) begin
          os_d    = '0;
          state_d = rxs ? S_IDLE : S_DATA;  // high at mid-start is a glitch
        end
      end
      S_DATA: begin
        if (samp_full) begin
          os_d   = '0;
          data_d = {rxs, data_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (samp_full) begin
          os_d    = '0;
          perr_d  = (rxs != exp_par);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
`ifdef UART_RX_BREAK_DETECT_EN
        // Break candidate: wait out the rest of the frame, then for line high.
        if (brk_q) begin
          if (rxs) begin
            state_d  = S_IDLE;
            brk_d    = 1'b0;
            brkhit_d = 1'b0;
            if (!brkhit_q) begin
              push     = 1'b1;  // line recovered early: plain framing error
              push_err = {perr_q, 1'b1};
            end
          end else if (!brkhit_q && samp_half) begin
            brkhit_d = 1'b1;
            break_d  = 1'b1;
          end
        end else
`endif
        if (samp_full) begin
          os_d   = '0;
          ferr_d = ferr_n;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_RX_BREAK_DETECT_EN
            if (data_q == '0 && ferr_n) begin
              brk_d = 1'b1;
            end else begin
              push    = 1'b1;
              state_d = S_IDLE;
            end
`else
            push    = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign level = wptr_q - rptr_q;
  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign pop   = !empty && rd.rready_i;
  assign wr_en = push && !clear_i && (!full || pop);

  // FIFO pointers and sticky overrun: clear wins over a coincident push.
  always_comb begin
    wptr_d = clear_i ? '0 : wptr_q + LW'(wr_en);
    rptr_d = clear_i ? '0 : rptr_q + LW'(pop);
    ovr_d  = clear_i ? 1'b0 : (ovr_q | (push && full && !pop));
  end

  // State registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      os_q     <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q    <= 1'b0;
      brkhit_q <= 1'b0;
      break_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      os_q     <= os_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovr_q    <= ovr_d;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q    <= brk_d;
      brkhit_q <= brkhit_d;
      break_q  <= break_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care while empty, outputs are masked.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= {push_err, data_q};
  end

  assign head        = mem_q[rptr_q[AW-1:0]];
  assign rd.rvalid_o = !empty;
  assign rd.rdata_o  = empty ? '0 : head[DATA_BITS-1:0];
  assign rd.rerr_o   = empty ? '0 : head[EW-1:DATA_BITS];
  assign level_o     = level;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_o     = break_q;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to the fixed 8-bit, fixed-rate UART receiver that captures core stdout on the bench.
- Adds configurable data width, parity, stop bits and oversampling.
- Adds per-character error tagging and a receive FIFO with a valid/ready read port, so the consumer does not have to sample on a one-cycle strobe.
- Sits between the DUT Tx line and the print/exit monitor; also synthesisable for board-level console capture.

Parameters:
- CLOCK_RATE, 100000000: input clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit; must be an even number, at least 8.
- DATA_BITS, 8: data bits per character, range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: number of receive FIFO entries; must be a power of two, at least 2.

Ports:
- clk_i  in  1: clock.
- rst_ni  in  1: asynchronous reset, active low.
- rx_i  in  1: serial line; asynchronous; idle high.
- rx_en_i  in  1: receive enable.
- clear_i  in  1: synchronous pulse; clears the sticky flags and flushes the FIFO.
- rdata_o  out  DATA_BITS: FIFO head data.
- rerr_o  out  2: FIFO head error tag; bit0 = framing, bit1 = parity.
- rvalid_o  out  1: FIFO not empty.
- rready_i  in  1: pop the head when rvalid_o is high.
- level_o  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- overrun_o  out  1: sticky; a character was dropped because the FIFO was full.
- busy_o  out  1: a frame is in progress.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM goes to IDLE; FIFO is emptied; synchronizer flops are set to 1.
  - rvalid_o=0, level_o=0, overrun_o=0, busy_o=0, rdata_o=0, rerr_o=0.
  - Reset asserted mid-frame aborts the frame; nothing is pushed.
- Input conditioning: rx_i passes through a 2-flop synchronizer. All line decisions below use the synchronized signal rxs.
- Tick generator:
  - DIV = CLOCK_RATE/(BAUD_RATE*OVERSAMPLE), rounded to nearest.
  - Counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - The counter is restarted on the IDLE->START transition so ticks align with the falling edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rxs falling while rx_en_i=1 -> START. busy_o=0 in IDLE only.
  - START: after OVERSAMPLE/2 ticks, sample rxs. If low -> DATA with sample counter reset. If high, treat as a glitch -> IDLE, no push.
  - DATA: sample every OVERSAMPLE ticks, LSB first, into a shift register. After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
  - PARITY: sample one bit and compare with the XOR of the data bits. Even parity expects XOR; odd parity expects ~XOR. A mismatch sets the parity error tag.
  - STOP: sample STOP_BITS bits. Any stop sample that is low sets the framing error tag. Push occurs on the cycle of the last stop sample -> IDLE.
  - Return to IDLE is at mid-stop, so a start edge arriving immediately after is caught.
- Latency: the pushed character is visible on rdata_o/rvalid_o one cycle after the last stop sample.
- rx_en_i low:
  - Blocks new start detection only.
  - A frame already in progress completes and is pushed.
- FIFO:
  - First-word-fall-through, with registered read/write pointers that carry one extra wrap bit.
  - rdata_o and rerr_o are stable while rvalid_o=1 and rready_i=0.
  - Pop occurs when rvalid_o && rready_i; rready_i while empty is ignored.
  - Push and pop in the same cycle: level is unchanged. When the FIFO is full, a pop in the same cycle makes room, so the push is accepted and no overrun occurs.
  - Push while full with no pop: the character is dropped, overrun_o goes to 1 on the next cycle and stays 1 until clear_i or reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Error tags: a character with an error is still pushed, carrying its tag. Errors never stall the FSM.
- clear_i:
  - Empties the FIFO and clears overrun_o in the following cycle.
  - Does not disturb a frame in progress.
  - If clear_i coincides with a push, clear wins and the character is discarded.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - Adds output break_o (1 bit).
  - When the frame has all-zero data and a low stop sample, and rxs stays low for a full frame time (1+DATA_BITS+parity+STOP_BITS bit times) measured from the start edge, break_o pulses high for one cycle. The character is not pushed.
  - The FSM then waits in STOP until rxs returns high, then goes to IDLE.
- Undefined:
  - No break_o port and no break counter.
  - A break is received as a 0x00 character with a framing error, followed by IDLE; a further start is detected only after rxs returns high.

Test Plan:
- Defaults (DIV=651, bit = 10416 clk): send 8N1 0x41 -> rdata_o=0x41, rerr_o=00, level_o=1, rvalid_o rises 98952±3 clk after the start edge; pulse rready_i -> level_o=0, rvalid_o=0.
- rx_i low for 3000 clk, then high (shorter than half a bit) -> no push, busy_o returns to 0, level_o stays 0.
- Send 0x55 with a low stop bit -> rdata_o=0x55, rerr_o=01. Then send 0x0F with a good stop bit back-to-back -> second entry has rerr_o=00.
- PARITY=2: send 0x07 with parity bit 0 -> rerr_o=10. Send 0x07 with parity bit 1 -> rerr_o=00.
- FIFO_DEPTH=16, rready_i=0: send 17 characters 0x00..0x10 -> level_o=16, overrun_o=1, head=0x00, 0x10 is lost. Pulse clear_i -> level_o=0, overrun_o=0. Apply rst_ni low mid-frame -> all outputs return to reset values.
- With UART_RX_BREAK_DETECT_EN: hold rx_i low for 3 frame times -> one break_o pulse, level_o=0. Release rx_i, send 0x33 -> received cleanly.
